// File: rtl/uart_tx_tick_pkg.sv
// uart_tx_tick_pkg
// Shared definitions for the tick-driven UART transmitter:
//   - tx_state_e : transmitter FSM state encoding (3-bit register)
//   - BIT_IDX_W  : width of the bit index / bit counter
//   - frame_len(): number of bit-rate ticks in one serial frame
package uart_tx_tick_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } tx_state_e;

   // Wide enough for the longest legal frame: 1 + 9 + 1 + 2 = 13 bits.
   localparam int BIT_IDX_W = 4;

   // Start bit + data bits + optional parity bit + stop bits.
   function automatic int frame_len(input int data_w, input int parity_en, input int stop_bits);
      return 1 + data_w + ((parity_en != 0) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_tick.sv
// uart_tx_tick
// Serial transmitter that advances one bit per bit-rate tick (ce). A start
// strobe latches the parallel word and computes its parity; the frame then
// waits for a full tick before the start bit so every bit lasts exactly one
// tick period.
//
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   ce      : bit-rate tick, one clk wide per bit period
//   st      : start strobe, honoured only while idle
//   dat     : parallel data, latched on an accepted st
//   txd     : serial line, idles high
//   busy    : frame pending or in progress
//   done    : one-clk pulse at frame completion
//   bit_idx : bit currently on txd (0 = start, 1..DATA_W = data, then
//             parity, then stop bits); 0 while idle or armed
module uart_tx_tick
   import uart_tx_tick_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ce,
   input  logic                 st,
   input  logic [DATA_W-1:0]    dat,
   output logic                 txd,
   output logic                 busy,
   output logic                 done,
   output logic [BIT_IDX_W-1:0] bit_idx
);

   localparam logic [BIT_IDX_W-1:0] LAST_DATA_IDX = BIT_IDX_W'(DATA_W);
   localparam logic [BIT_IDX_W-1:0] LAST_IDX      =
      BIT_IDX_W'(frame_len(DATA_W, PARITY_EN, STOP_BITS) - 1);
   localparam logic                 PAR_INV       = (PARITY_ODD != 0);

   tx_state_e             state_q,   state_d;
   logic [DATA_W-1:0]     shift_q,   shift_d;
   logic                  par_q,     par_d;
   logic                  txd_q,     txd_d;
   logic                  busy_q,    busy_d;
   logic                  done_q,    done_d;
   logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;

   // Next-state logic. Everything holds by default; done is a pulse so it
   // defaults low. bit_idx is updated together with txd so it always names
   // the bit currently on the line.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      par_d     = par_q;
      txd_d     = txd_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bit_idx_d = bit_idx_q;

      unique case (state_q)
         ST_IDLE: begin
            txd_d     = 1'b1;
            busy_d    = 1'b0;
            bit_idx_d = '0;
            // A ce in the same cycle as st is deliberately not used: the
            // ARM state waits for the next one so the start bit is full.
            if (st) begin
               shift_d = dat;
               par_d   = (^dat) ^ PAR_INV;
               busy_d  = 1'b1;
               state_d = ST_ARM;
            end
         end

         ST_ARM: begin
            if (ce) begin
               txd_d     = 1'b0;
               bit_idx_d = '0;
               state_d   = ST_START;
            end
         end

         ST_START: begin
            if (ce) begin
               txd_d     = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + 1'b1;
               state_d   = ST_DATA;
            end
         end

         ST_DATA: begin
            if (ce) begin
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == LAST_DATA_IDX) begin
                  if (PARITY_EN != 0) begin
                     txd_d   = par_q;
                     state_d = ST_PARITY;
                  end else begin
                     txd_d   = 1'b1;
                     state_d = ST_STOP;
                  end
               end else begin
                  txd_d   = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end

         ST_PARITY: begin
            if (ce) begin
               txd_d     = 1'b1;
               bit_idx_d = bit_idx_q + 1'b1;
               state_d   = ST_STOP;
            end
         end

         ST_STOP: begin
            // The tick that ends the last stop bit closes the frame.
            if (ce) begin
               if (bit_idx_q == LAST_IDX) begin
                  txd_d     = 1'b1;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  bit_idx_d = '0;
                  state_d   = ST_IDLE;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end

         default: begin
            txd_d     = 1'b1;
            busy_d    = 1'b0;
            bit_idx_d = '0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any frame in flight at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         par_q     <= 1'b0;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bit_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         txd_q     <= txd_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bit_idx_q <= bit_idx_d;
      end
   end

   assign txd     = txd_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign bit_idx = bit_idx_q;

endmodule

// File: tb/tb_uart_tx_tick.sv
// tb_uart_tx_tick
// Drives three transmitter configurations in lockstep from shared inputs:
//   dut 0 : 8 data bits, even parity, 1 stop bit
//   dut 1 : 8 data bits, odd parity,  1 stop bit
//   dut 2 : 8 data bits, no parity,   2 stop bits
// All three frames are 11 ticks long. The expected line is built from the
// frame rules (start 0, data LSB first, parity from the popcount, stop 1s)
// and compared tick by tick.
module tb_uart_tx_tick;

   logic       clk;
   logic       rst_n;
   logic       ce;
   logic       st;
   logic [7:0] dat;

   logic       txd_o  [3];
   logic       busy_o [3];
   logic       done_o [3];
   logic [3:0] bidx_o [3];

   int errors;
   int checks;

   // ce generation, standing in for the upstream divider
   logic ce_auto;
   logic ce_manual;
   int   ce_period;
   int   ce_cnt;

   uart_tx_tick #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .ce(ce), .st(st), .dat(dat),
      .txd(txd_o[0]), .busy(busy_o[0]), .done(done_o[0]), .bit_idx(bidx_o[0]));

   uart_tx_tick #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .ce(ce), .st(st), .dat(dat),
      .txd(txd_o[1]), .busy(busy_o[1]), .done(done_o[1]), .bit_idx(bidx_o[1]));

   uart_tx_tick #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .ce(ce), .st(st), .dat(dat),
      .txd(txd_o[2]), .busy(busy_o[2]), .done(done_o[2]), .bit_idx(bidx_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ce changes 2 time units after each rising edge, so it is stable both
   // when tasks read it at the falling edge and at the next rising edge.
   always @(posedge clk) begin
      #2;
      if (ce_auto) begin
         ce_cnt = (ce_cnt + 1) % ce_period;
         ce     = (ce_cnt == 0);
      end else begin
         ce = ce_manual;
      end
   end

   // Expected line level for each tick of a frame: bit k is what txd shows
   // after the k-th tick following the accepted start strobe, minus one.
   function automatic logic [15:0] frame_bits(input logic [7:0] d, input int pe, input int po);
      logic [15:0] f;
      f    = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
      if (pe != 0) f[9] = (($countones(d) % 2) == 1) ^ (po != 0);
      return f;
   endfunction

   // Sends one frame and checks every dut at every clock until the tick
   // after the last stop bit. Optional: align st with a ce, inject a second
   // st with 8'hFF mid-frame, or assert reset after tick abort_at.
   task automatic send_frame(input logic [7:0] d, input int wait_cyc, input bit align_ce,
                             input bit inject, input int abort_at);
      logic [15:0] f [3];
      int          flen [3];
      int          k;
      int          cyc;
      int          guard;
      logic        cur_ce;
      logic        e_txd, e_busy, e_done;
      logic [3:0]  e_idx;

      f[0] = frame_bits(d, 1, 0);  flen[0] = 1 + 8 + 1 + 1;
      f[1] = frame_bits(d, 1, 1);  flen[1] = 1 + 8 + 1 + 1;
      f[2] = frame_bits(d, 0, 0);  flen[2] = 1 + 8 + 0 + 2;

      repeat (wait_cyc) @(negedge clk);
      @(negedge clk);
      if (align_ce) begin
         guard = 0;
         while (ce !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
         end
         checks++;
         if (ce !== 1'b1) begin
            errors++;
            $display("[TB] FAIL align_ce: ce got %b want 1 within 64 clocks", ce);
         end
      end
      st  = 1'b1;
      dat = d;

      k   = 0;
      cyc = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (busy_o[i] !== 1'b1 || txd_o[i] !== 1'b1 || done_o[i] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL accept dut%0d: busy/txd/done got %b%b%b want 110",
                     i, busy_o[i], txd_o[i], done_o[i]);
         end
      end

      while (k < 12 && cyc < 12 * ce_period + 8) begin
         @(negedge clk);
         st = 1'b0;
         if (inject && k == 3) begin
            st  = 1'b1;
            dat = 8'hFF;
         end
         @(posedge clk);
         #1;
         cur_ce = ce;
         if (cur_ce) k++;
         cyc++;
         for (int i = 0; i < 3; i++) begin
            if (k == 0) begin
               e_txd = 1'b1; e_busy = 1'b1; e_done = 1'b0; e_idx = 4'd0;
            end else if (k <= flen[i]) begin
               e_txd = f[i][k-1]; e_busy = 1'b1; e_done = 1'b0; e_idx = 4'(k - 1);
            end else begin
               e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b1; e_idx = 4'd0;
            end
            checks++;
            if (txd_o[i] !== e_txd) begin
               errors++;
               $display("[TB] FAIL txd dut%0d tick %0d: got %b want %b", i, k, txd_o[i], e_txd);
            end
            checks++;
            if (busy_o[i] !== e_busy) begin
               errors++;
               $display("[TB] FAIL busy dut%0d tick %0d: got %b want %b", i, k, busy_o[i], e_busy);
            end
            checks++;
            if (done_o[i] !== e_done) begin
               errors++;
               $display("[TB] FAIL done dut%0d tick %0d: got %b want %b", i, k, done_o[i], e_done);
            end
            checks++;
            if (bidx_o[i] !== e_idx) begin
               errors++;
               $display("[TB] FAIL bit_idx dut%0d tick %0d: got %0d want %0d", i, k, bidx_o[i], e_idx);
            end
         end
         if (abort_at > 0 && k == abort_at) begin
            #2;
            rst_n = 1'b0;
            #1;
            for (int i = 0; i < 3; i++) begin
               checks++;
               if (txd_o[i] !== 1'b1 || busy_o[i] !== 1'b0 || done_o[i] !== 1'b0 || bidx_o[i] !== 4'd0) begin
                  errors++;
                  $display("[TB] FAIL async_reset dut%0d: txd/busy/done/bit_idx got %b/%b/%b/%0d want 1/0/0/0",
                           i, txd_o[i], busy_o[i], done_o[i], bidx_o[i]);
               end
            end
            @(negedge clk);
            rst_n = 1'b1;
            st    = 1'b0;
            return;
         end
      end
      st = 1'b0;
      checks++;
      if (k < 12) begin
         errors++;
         $display("[TB] FAIL frame_timeout: ticks got %0d want 12", k);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (txd_o[i] !== 1'b1 || busy_o[i] !== 1'b0 || done_o[i] !== 1'b0 || bidx_o[i] !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset dut%0d: txd/busy/done/bit_idx got %b/%b/%b/%0d want 1/0/0/0",
                     i, txd_o[i], busy_o[i], done_o[i], bidx_o[i]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_idle_ce();
      ce_auto = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         ce_manual = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (txd_o[i] !== 1'b1 || busy_o[i] !== 1'b0 || done_o[i] !== 1'b0) begin
               errors++;
               $display("[TB] FAIL idle_ce dut%0d cycle %0d: txd/busy/done got %b/%b/%b want 1/0/0",
                        i, c, txd_o[i], busy_o[i], done_o[i]);
            end
         end
      end
      @(negedge clk);
      ce_manual = 1'b0;
      ce_cnt    = 0;
      ce_period = 4;
      ce_auto   = 1'b1;
   endtask

   task automatic test_default_frame();
      ce_period = 4;
      send_frame(8'hA5, 3, 1'b0, 1'b0, 0);
      send_frame(8'h00, 5, 1'b0, 1'b0, 0);
   endtask

   task automatic test_coincident_start();
      ce_period = 4;
      send_frame(8'hA5, 2, 1'b1, 1'b1, 0);
   endtask

   task automatic test_back_to_back();
      ce_period = 3;
      send_frame(8'hA5, 1, 1'b0, 1'b0, 0);
      send_frame(8'h3C, 0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_reset_mid();
      ce_period = 4;
      send_frame(8'hA5, 1, 1'b0, 1'b0, 5);
      send_frame(8'h5A, 2, 1'b0, 1'b0, 0);
   endtask

   task automatic test_random_frames();
      for (int n = 0; n < 10; n++) begin
         ce_period = $urandom_range(1, 6);
         send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      st        = 1'b0;
      dat       = 8'h00;
      ce        = 1'b0;
      ce_auto   = 1'b0;
      ce_manual = 1'b0;
      ce_period = 4;
      ce_cnt    = 0;
      rst_n     = 1'b0;

      test_reset();
      test_idle_ce();
      test_default_frame();
      test_coincident_start();
      test_back_to_back();
      test_reset_mid();
      test_random_frames();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
